// File: rtl/main_fsm.sv
// Multicycle RISC-V main control FSM: sequences fetch, decode, memory, ALU and
// branch steps and drives the datapath select/enable lines as a Moore decode.
module main_fsm #(
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       fault,
    output logic [3:0] state
);

    localparam int unsigned OP_W  = 7;
    localparam int unsigned ST_W  = 4;

    localparam logic [OP_W-1:0] OP_LW   = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OP_RTYP = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OP_ITYP = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(7'b1101111);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(7'b1100011);

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_FAULT    = 4'd15
    } state_t;

    state_t state_q;

    // State sequencing; unused encodings fall back to FETCH, FAULT only leaves via reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:    if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_RTYP:      state_q <= S_EXECR;
                        OP_ITYP:      state_q <= S_EXECI;
                        OP_JAL:       state_q <= S_JAL;
                        OP_BEQ:       state_q <= S_BEQ;
                        default:      state_q <= ILLEGAL_TRAP ? S_FAULT : S_FETCH;
                    endcase
                end
                S_MEMADR:   state_q <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready) state_q <= S_MEMWB;
                S_MEMWB:    state_q <= S_FETCH;
                S_MEMWRITE: if (mem_ready) state_q <= S_FETCH;
                S_EXECR:    state_q <= S_ALUWB;
                S_EXECI:    state_q <= S_ALUWB;
                S_ALUWB:    state_q <= S_FETCH;
                S_JAL:      state_q <= S_ALUWB;
                S_BEQ:      state_q <= S_FETCH;
                S_FAULT:    state_q <= S_FAULT;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    // Moore output decode of the state register; only FETCH looks at mem_ready.
    always_comb begin
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        fault     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCUpdate  = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have parameter ILLEGAL_TRAP, default 1: if 1, an unknown opcode enters FAULT (sticky); if 0, it returns to FETCH.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port op, input, 7 bits: opcode field of the instruction register.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-006 SHALL have outputs PCUpdate, Branch, RegWrite, MemWrite, IRWrite and AdrSrc, 1 bit each.
REQ-007 SHALL have outputs ResultSrc, ALUSrcA, ALUSrcB and ALUOp, 2 bits each; ALUOp feeds the ALU decoder (00 add, 01 subtract, 10 funct-decoded).
REQ-008 SHALL have output fault, 1 bit: FAULT state reached.
REQ-009 SHALL have output state, 4 bits: current state encoding, for debug.

Function
REQ-010 SHALL implement states with fixed encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, JAL=9, BEQ=10, FAULT=15; other encodings SHALL go to FETCH on the next edge.
REQ-011 SHALL drive outputs as a Moore function of state only, except for the mem_ready gating in REQ-012; every output not listed for a state SHALL be 0.
REQ-012 FETCH SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, and IRWrite=PCUpdate=mem_ready; it SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-013 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00, and branch on op as follows.
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECR.
- 0010011 -> EXECI.
- 1101111 -> JAL.
- 1100011 -> BEQ.
- Any other op -> FAULT if ILLEGAL_TRAP=1, else FETCH.
REQ-014 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00; it SHALL go to MEMREAD if op=0000011, else MEMWRITE.
REQ-015 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00; it SHALL hold until mem_ready=1, then go to MEMWB.
REQ-016 MEMWB SHALL drive ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-017 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1 continuously while held; it SHALL hold until mem_ready=1, then go to FETCH.
REQ-018 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10, then go to ALUWB; EXECI SHALL be identical except ALUSrcB=01.
REQ-019 ALUWB SHALL drive ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-020 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, then go to ALUWB.
REQ-021 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, then go to FETCH.
REQ-022 FAULT SHALL drive fault=1 with all enables 0, and SHALL remain in FAULT until reset.
REQ-023 SHALL ignore mem_ready in every state other than FETCH, MEMREAD and MEMWRITE.
REQ-024 Instruction latencies from FETCH accept, in cycles: lw 5, sw 4, R/I 4, jal 4, beq 3 (mem_ready=1 throughout).

Reset
REQ-025 reset=0 SHALL force state=FETCH immediately, without waiting for clk, including mid-stall or in FAULT.
REQ-026 While reset=0, outputs SHALL equal the FETCH decode with mem_ready gating, and fault=0.
REQ-027 The first transition SHALL occur on the first rising clk edge after reset deasserts.

Verification
REQ-028 lw: op=0000011, mem_ready=1 -> state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01.
REQ-029 sw with memory stall: op=0100011, mem_ready=0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, then state=0.
REQ-030 Fetch stall: mem_ready=0 for 2 cycles -> state holds 0 with IRWrite=PCUpdate=0; mem_ready=1 -> IRWrite=PCUpdate=1 in that cycle, then state=1.
REQ-031 beq: op=1100011 -> sequence 0,1,10,0; ALUOp=01 and Branch=1 in state 10. R-type: op=0110011 -> sequence 0,1,6,8,0 with ALUOp=10 in state 6.
REQ-032 Illegal opcode: op=1111111 with ILLEGAL_TRAP=1 -> state=15, fault=1, held for 10 cycles; with ILLEGAL_TRAP=0 -> state=0 after DECODE.
REQ-033 Asynchronous reset: assert reset=0 between clock edges while in MEMREAD -> state=0 and fault=0 before the next edge.
